rv32i_regfile_port_arbiter: RTL and testbench

Arbitrates the single-port integer register file between two requesters: decode-stage operand reads and writeback-stage result writes. Grants one access at a time and sequences the register-file read latency. Returns read data to decode with a valid pulse and acknowledges writes to writeback. Services x0 internally without touching the array. Sits between the decode stage, the writeback stage and the register file macro.

---
 rtl/rv32i_regfile_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_rv32i_regfile_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile_port_arbiter.sv
// Single-port integer register file arbiter: decode reads vs. writeback writes, x0 served locally.
// Optional RF_WB_BYPASS_EN: same-address read/write in one sample cycle forwards write data to decode.
module rv32i_regfile_port_arbiter #(
  parameter int WORD_SIZE       = 32,
  parameter int RF_READ_LATENCY = 1,
  parameter int MAX_WB_STREAK   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_dec_read_en,
  input  logic [4:0]           i_dec_read_addr,
  output logic                 o_dec_read_valid,
  output logic [WORD_SIZE-1:0] o_dec_read_data,
  input  logic                 i_wb_write_en,
  input  logic [4:0]           i_wb_write_addr,
  input  logic [WORD_SIZE-1:0] i_wb_write_data,
  output logic                 o_wb_write_ack,
  output logic                 o_rf_en,
  output logic                 o_rf_we,
  output logic [4:0]           o_rf_addr,
  output logic [WORD_SIZE-1:0] o_rf_wdata,
  input  logic [WORD_SIZE-1:0] i_rf_rdata
);

  localparam logic [2:0] LAT_INIT   = 3'(RF_READ_LATENCY);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_WB_STREAK);

  typedef enum logic [1:0] {ArbIdle, ArbReadWait, ArbReadDone} arb_state_t;

  arb_state_t           state_q, state_d;
  logic [3:0]           streak_q, streak_d;
  logic [2:0]           lat_q, lat_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 rf_en_q, rf_en_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_addr_q, rf_addr_d;
  logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;

  logic can_sample;
  logic force_read;
  logic bypass_hit;
  logic grant_wr;
  logic grant_rd;

  // A request still held during its own response cycle must not be granted twice.
  assign can_sample = (state_q == ArbIdle) && !rd_valid_q && !wr_ack_q;
  assign force_read = i_dec_read_en && (streak_q == STREAK_MAX);

`ifdef RF_WB_BYPASS_EN
  assign bypass_hit = i_dec_read_en && i_wb_write_en &&
                      (i_dec_read_addr == i_wb_write_addr) && (i_wb_write_addr != 5'd0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign grant_wr = can_sample && i_wb_write_en && (!force_read || bypass_hit);
  assign grant_rd = can_sample && i_dec_read_en && (!grant_wr || bypass_hit);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ArbIdle;
      streak_q   <= '0;
      lat_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      lat_q      <= lat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rf_en_q    <= rf_en_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    lat_d      = lat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    rf_en_d    = 1'b0;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      ArbIdle: begin
        if (grant_wr) begin
          wr_ack_d = 1'b1;
          if (i_wb_write_addr != 5'd0) begin
            rf_en_d    = 1'b1;
            rf_we_d    = 1'b1;
            rf_addr_d  = i_wb_write_addr;
            rf_wdata_d = i_wb_write_data;
          end
          if (i_dec_read_en) streak_d = streak_q + 4'd1;
        end
        if (grant_rd) begin
          streak_d = '0;
          if (bypass_hit) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_wb_write_data;
          end else if (i_dec_read_addr == 5'd0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
          end else begin
            rf_en_d   = 1'b1;
            rf_we_d   = 1'b0;
            rf_addr_d = i_dec_read_addr;
            lat_d     = LAT_INIT;
            state_d   = ArbReadWait;
          end
        end
      end
      ArbReadWait: begin
        if (lat_q == 3'd0) begin
          rd_data_d  = i_rf_rdata;
          rd_valid_d = 1'b1;
          state_d    = ArbReadDone;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ArbReadDone: state_d = ArbIdle;
      default:     state_d = ArbIdle;
    endcase

    if (!i_dec_read_en) streak_d = '0;
  end

  assign o_dec_read_valid = rd_valid_q;
  assign o_dec_read_data  = rd_data_q;
  assign o_wb_write_ack   = wr_ack_q;
  assign o_rf_en          = rf_en_q;
  assign o_rf_we          = rf_we_q;
  assign o_rf_addr        = rf_addr_q;
  assign o_rf_wdata       = rf_wdata_q;

endmodule

// File: tb/tb_rv32i_regfile_port_arbiter.sv
// Bench for rv32i_regfile_port_arbiter: queue-driven requesters, array model and
// architectural-register scoreboard; directed scenarios followed by random traffic.
module tb_rv32i_regfile_port_arbiter;
  localparam int W    = 32;
  localparam int LAT  = 1;
  localparam int MAXS = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_dec_read_en = 1'b0;
  logic [4:0]   i_dec_read_addr = '0;
  logic         o_dec_read_valid;
  logic [W-1:0] o_dec_read_data;
  logic         i_wb_write_en = 1'b0;
  logic [4:0]   i_wb_write_addr = '0;
  logic [W-1:0] i_wb_write_data = '0;
  logic         o_wb_write_ack;
  logic         o_rf_en;
  logic         o_rf_we;
  logic [4:0]   o_rf_addr;
  logic [W-1:0] o_rf_wdata;
  logic [W-1:0] i_rf_rdata = '0;

  rv32i_regfile_port_arbiter #(
    .WORD_SIZE(W), .RF_READ_LATENCY(LAT), .MAX_WB_STREAK(MAXS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_dec_read_en(i_dec_read_en), .i_dec_read_addr(i_dec_read_addr),
    .o_dec_read_valid(o_dec_read_valid), .o_dec_read_data(o_dec_read_data),
    .i_wb_write_en(i_wb_write_en), .i_wb_write_addr(i_wb_write_addr),
    .i_wb_write_data(i_wb_write_data), .o_wb_write_ack(o_wb_write_ack),
    .o_rf_en(o_rf_en), .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr),
    .o_rf_wdata(o_rf_wdata), .i_rf_rdata(i_rf_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [4:0] addr; logic [W-1:0] data; int gap; } wr_req_t;
  typedef struct { logic [4:0] addr; int gap; } rd_req_t;

  wr_req_t      wr_q[$];
  rd_req_t      rd_q[$];
  logic [W-1:0] arch [32];
  logic [W-1:0] mem  [32];
  int           pipe_cyc[$];
  logic [4:0]   pipe_addr[$];
  int           strobe_cyc[$];
  logic [4:0]   strobe_addr[$];

  int total = 0, bad = 0;
  int cyc = 0;
  bit wb_active = 0, rd_active = 0, ack_seen = 0, valid_seen = 0;
  int wb_gap = 0, rd_gap = 0, wb_start_cyc = 0, rd_start_cyc = 0;
  bit rf_en_prev = 0, rd_en_prev = 0, issue_pending = 0;
  int issue_cyc = 0, last_issue_cyc = 0, last_valid_cyc = 0, last_ack_cyc = 0;
  int ack_cnt = 0, valid_cnt = 0, issue_cnt = 0, ack_cnt_at_valid = 0, streak_obs = 0;
  logic [W-1:0] last_valid_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Requesters: present the queue head as a held level request until its response pulse.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        wb_active = 0; rd_active = 0; i_wb_write_en = 0; i_dec_read_en = 0;
      end else begin
        if (wb_active && ack_seen) begin
          wb_active = 0; i_wb_write_en = 0; wr_q.delete(0);
        end
        if (rd_active && valid_seen) begin
          rd_active = 0; i_dec_read_en = 0; rd_q.delete(0);
        end
        if (!wb_active && wr_q.size() > 0) begin
          if (wb_gap < wr_q[0].gap) wb_gap++;
          else begin
            wb_gap = 0; wb_active = 1; i_wb_write_en = 1;
            i_wb_write_addr = wr_q[0].addr; i_wb_write_data = wr_q[0].data;
            wb_start_cyc = cyc;
          end
        end
        if (!rd_active && rd_q.size() > 0) begin
          if (rd_gap < rd_q[0].gap) rd_gap++;
          else begin
            rd_gap = 0; rd_active = 1; i_dec_read_en = 1;
            i_dec_read_addr = rd_q[0].addr;
            rd_start_cyc = cyc;
          end
        end
      end
      ack_seen = 0; valid_seen = 0;
    end
  end

  // Array model, scoreboard against architectural state, protocol properties.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      pipe_cyc.delete(); pipe_addr.delete();
      issue_pending = 0; rf_en_prev = 0; rd_en_prev = 0; streak_obs = 0;
      i_rf_rdata = $urandom;
    end else begin
      if (o_rf_en) begin
        check("rf_en_gap", 64'(rf_en_prev), 64'(0));
        if (o_rf_we) begin
          check("wr_strobe_ack", 64'(o_wb_write_ack), 64'(1));
          mem[o_rf_addr] = o_rf_wdata;
          strobe_cyc.push_back(cyc); strobe_addr.push_back(o_rf_addr);
        end else begin
          check("rd_issue_addr", 64'({i_dec_read_en, o_rf_addr}), 64'({1'b1, i_dec_read_addr}));
          pipe_cyc.push_back(cyc); pipe_addr.push_back(o_rf_addr);
          issue_pending = 1; issue_cyc = cyc; last_issue_cyc = cyc; issue_cnt++;
        end
      end
      if (o_wb_write_ack) begin
        ack_seen = 1; ack_cnt++; last_ack_cyc = cyc;
        if (i_wb_write_addr != 5'd0) begin
          check("wr_strobe", 64'({o_rf_en, o_rf_we, o_rf_addr}), 64'({2'b11, i_wb_write_addr}));
          check("wr_data", 64'(o_rf_wdata), 64'(i_wb_write_data));
          arch[i_wb_write_addr] = i_wb_write_data;
        end else begin
          check("wr_x0_no_access", 64'(o_rf_en), 64'(0));
        end
        if (rd_en_prev) begin
          streak_obs++;
          check("streak_bound", 64'(streak_obs <= MAXS), 64'(1));
        end else begin
          streak_obs = 0;
        end
      end
      if (o_dec_read_valid) begin
        valid_seen = 1; valid_cnt++; last_valid_cyc = cyc;
        last_valid_data = o_dec_read_data; ack_cnt_at_valid = ack_cnt;
        check("rd_data", 64'(o_dec_read_data), 64'(arch[i_dec_read_addr]));
`ifdef RF_WB_BYPASS_EN
        if (o_wb_write_ack) check("bypass_addr", 64'(i_wb_write_addr), 64'(i_dec_read_addr));
        else
`else
        check("rd_no_ack_overlap", 64'(o_wb_write_ack), 64'(0));
`endif
        if (i_dec_read_addr != 5'd0) begin
          check("rd_issue_seen", 64'(issue_pending), 64'(1));
          check("rd_latency", 64'(cyc - issue_cyc), 64'(LAT + 1));
        end else begin
          check("rd_x0_no_access", 64'(o_rf_en | issue_pending), 64'(0));
        end
        issue_pending = 0; streak_obs = 0;
      end
      if (!i_dec_read_en) streak_obs = 0;
      rf_en_prev = o_rf_en; rd_en_prev = i_dec_read_en;
      if (pipe_cyc.size() > 0 && cyc == pipe_cyc[0] + LAT) begin
        i_rf_rdata = mem[pipe_addr[0]];
        pipe_cyc.delete(0); pipe_addr.delete(0);
      end else begin
        i_rf_rdata = $urandom;
      end
    end
  end

  task automatic nclk();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((wr_q.size() > 0 || rd_q.size() > 0 || wb_active || rd_active) && n < bound) begin
      nclk();
      n++;
    end
    check("idle_timeout", 64'(n < bound), 64'(1));
    repeat (2) nclk();
  endtask

  task automatic preload(input logic [4:0] a, input logic [W-1:0] d);
    mem[a] = d;
    arch[a] = d;
  endtask

  function automatic logic any_out();
    return |{o_dec_read_valid, o_dec_read_data, o_wb_write_ack, o_rf_en, o_rf_we, o_rf_addr, o_rf_wdata};
  endfunction

  initial begin
    int ic0, vc0, ac0, sc0, n;
    logic [4:0] pool [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd17, 5'd31};

    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      arch[i] = mem[i];
    end
    mem[0] = 32'hBAD0_BAD0;
    arch[0] = '0;

    repeat (3) nclk();
    check("reset_outputs", 64'(any_out()), 64'(0));
    i_rst_n = 1;
    repeat (2) nclk();

    // Plain read of x5
    preload(5'd5, 32'hDEAD_BEEF);
    rd_q.push_back('{addr: 5'd5, gap: 0});
    wait_idle(50);
    check("x5_issue_cyc", 64'(last_issue_cyc - rd_start_cyc), 64'(1));
    check("x5_valid_cyc", 64'(last_valid_cyc - rd_start_cyc), 64'(LAT + 2));
    check("x5_data", 64'(last_valid_data), 64'(32'hDEAD_BEEF));

    // Reset while the read is waiting on the array
    rd_q.push_back('{addr: 5'd5, gap: 0});
    n = 0;
    while (!issue_pending && n < 20) begin nclk(); n++; end
    check("rst_mid_issue_timeout", 64'(n < 20), 64'(1));
    i_rst_n = 0;
    rd_q.delete();
    vc0 = valid_cnt;
    repeat (3) begin
      nclk();
      check("rst_mid_outputs", 64'(any_out()), 64'(0));
    end
    i_rst_n = 1;
    repeat (8) nclk();
    check("rst_no_late_valid", 64'(valid_cnt - vc0), 64'(0));
    preload(5'd6, 32'h0BAD_F00D);
    rd_q.push_back('{addr: 5'd6, gap: 0});
    wait_idle(50);
    check("post_rst_valid_cyc", 64'(last_valid_cyc - rd_start_cyc), 64'(LAT + 2));
    check("post_rst_data", 64'(last_valid_data), 64'(32'h0BAD_F00D));

    // x0 read and write
    ic0 = issue_cnt; sc0 = strobe_cyc.size();
    rd_q.push_back('{addr: 5'd0, gap: 0});
    wait_idle(50);
    check("x0_rd_cyc", 64'(last_valid_cyc - rd_start_cyc), 64'(1));
    check("x0_rd_data", 64'(last_valid_data), 64'(0));
    check("x0_rd_no_access", 64'(issue_cnt - ic0), 64'(0));
    wr_q.push_back('{addr: 5'd0, data: 32'h1234, gap: 0});
    wait_idle(50);
    check("x0_wr_ack_cyc", 64'(last_ack_cyc - wb_start_cyc), 64'(1));
    check("x0_wr_no_access", 64'(strobe_cyc.size() - sc0), 64'(0));

    // Write streak with a read of x7 pending
    ac0 = ack_cnt;
    for (int k = 0; k < 6; k++)
      wr_q.push_back('{addr: 5'(10 + k), data: $urandom, gap: 0});
    rd_q.push_back('{addr: 5'd7, gap: 0});
    wait_idle(200);
    check("streak_acks_before_rd", 64'(ack_cnt_at_valid - ac0), 64'(MAXS));
    check("streak_rd_issue_cyc", 64'(last_issue_cyc - rd_start_cyc), 64'(2 * MAXS + 1));
    check("streak_writes_resume", 64'(ack_cnt - ac0), 64'(6));

    // Simultaneous write and read of x9
    ic0 = issue_cnt;
    wr_q.push_back('{addr: 5'd9, data: 32'hCAFE_F00D, gap: 0});
    rd_q.push_back('{addr: 5'd9, gap: 0});
    wait_idle(50);
    check("same_addr_ack_cyc", 64'(last_ack_cyc - wb_start_cyc), 64'(1));
    check("same_addr_data", 64'(last_valid_data), 64'(32'hCAFE_F00D));
`ifdef RF_WB_BYPASS_EN
    check("bypass_valid_cyc", 64'(last_valid_cyc - rd_start_cyc), 64'(1));
    check("bypass_no_array_read", 64'(issue_cnt - ic0), 64'(0));
`else
    check("same_addr_valid_cyc", 64'(last_valid_cyc - rd_start_cyc), 64'(LAT + 4));
    check("same_addr_array_read", 64'(issue_cnt - ic0), 64'(1));
`endif

    // Back-to-back writes x1..x4
    sc0 = strobe_cyc.size(); ac0 = ack_cnt;
    for (int k = 1; k <= 4; k++)
      wr_q.push_back('{addr: 5'(k), data: $urandom, gap: 0});
    wait_idle(50);
    check("b2b_strobe_count", 64'(strobe_cyc.size() - sc0), 64'(4));
    check("b2b_ack_count", 64'(ack_cnt - ac0), 64'(4));
    if (strobe_cyc.size() - sc0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("b2b_addr", 64'(strobe_addr[sc0 + k]), 64'(k + 1));
        if (k > 0) check("b2b_spacing", 64'(strobe_cyc[sc0 + k] - strobe_cyc[sc0 + k - 1]), 64'(2));
      end
    end

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      wr_q.push_back('{addr: pool[$urandom_range(0, 6)], data: $urandom, gap: int'($urandom_range(0, 3))});
      rd_q.push_back('{addr: pool[$urandom_range(0, 6)], gap: int'($urandom_range(0, 3))});
    end
    wait_idle(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
